ad_mover_mc: RTL and testbench

Multi-channel successor to the single-channel AD sample mover. It scans up to CH_N ADC channels round-robin over a read_req/read_ready handshake and tags each sample with its channel. Samples are buffered in a FIFO_DEPTH-entry FIFO and delivered downstream over a write_req/write_ready handshake with backpressure. It sits between the ADC interface and the DSP core input, where the sample stream must survive short downstream stalls.

---
 rtl/ad_mover_mc_if.sv | 29 ++
 rtl/ad_mover_mc.sv | 167 ++++++++++++++++
 tb/tb_ad_mover_mc.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ad_mover_mc_if.sv
// ad_mover_mc_if: sample-mover bus bundle.
//   Read side  : read_req/read_ch (mover -> ADC), read_ready/read_data (ADC -> mover)
//   Write side : write_req/write_data/write_ch (mover -> DSP), write_ready (DSP -> mover)
// Modports:
//   master - the mover (ad_mover_mc)
//   slave  - the surrounding ADC interface and DSP input
interface ad_mover_mc_if #(
  parameter int DATA_W = 16,
  parameter int CH_W   = 2
);
  logic              read_req;
  logic [CH_W-1:0]   read_ch;
  logic              read_ready;
  logic [DATA_W-1:0] read_data;
  logic              write_req;
  logic              write_ready;
  logic [DATA_W-1:0] write_data;
  logic [CH_W-1:0]   write_ch;

  modport master (
    output read_req, read_ch, write_req, write_data, write_ch,
    input  read_ready, read_data, write_ready
  );

  modport slave (
    input  read_req, read_ch, write_req, write_data, write_ch,
    output read_ready, read_data, write_ready
  );
endinterface

// File: rtl/ad_mover_mc.sv
// ad_mover_mc: multi-channel AD sample mover.
// Scans enabled ADC channels round-robin, tags every sample with its channel,
// buffers {channel, sample} in a FIFO and hands the head downstream with
// backpressure.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous, active-low reset
//   ad_en      - read-side enable
//   read_quite - read-side pause (same effect as ad_en=0)
//   ch_mask    - bit i=1 scans channel i
//   bus        - ad_mover_mc_if.master (read and write handshakes)
//   fifo_level - entries held, 0..FIFO_DEPTH
//   overflow   - one-cycle pulse per dropped sample
//   drop_cnt   - saturating drop counter, present only when the macro
//                AD_MOVER_DROP_CNT_EN is defined
module ad_mover_mc #(
  parameter int DATA_W     = 16,
  parameter int CH_N       = 4,
  parameter int CH_W       = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ad_en,
  input  logic              read_quite,
  input  logic [CH_N-1:0]   ch_mask,
  ad_mover_mc_if.master     bus,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow
`ifdef AD_MOVER_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(FIFO_DEPTH);

  state_t            state, state_nxt;
  logic [CH_W-1:0]   rr_ptr;     // channel of the last completed capture
  logic [CH_W-1:0]   read_ch_q;
  logic [CH_W-1:0]   next_ch;
  logic [CH_W-1:0]   cand;
  logic              found;
  int                sel_idx;
  logic              rd_en;
  logic              load_ch;
  logic              capture;
  logic              pop;
  logic              push_ok;
  logic              drop;

  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
  logic [CH_W-1:0]   ch_mem   [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;

  assign rd_en = ad_en & ~read_quite;

  // Lowest enabled channel strictly above rr_ptr, wrapping past CH_N-1 to 0.
  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    next_ch = '0;
    found   = 1'b0;
    sel_idx = 0;
    cand    = '0;
    for (int k = 1; k <= CH_N; k++) begin
      sel_idx = (int'(rr_ptr) + k) % CH_N;
      cand    = CH_W'(sel_idx);
      if (!found && ch_mask[cand]) begin
        next_ch = cand;
        found   = 1'b1;
      end
    end
  end

  // Read FSM: next state. An abort wins over a simultaneous read_ready.
  always_comb begin
    state_nxt = state;
    load_ch   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (rd_en && (ch_mask != '0)) begin
          state_nxt = REQ;
          load_ch   = 1'b1;
        end
      end
      REQ: begin
        if (!rd_en) begin
          state_nxt = IDLE;
        end else if (bus.read_ready) begin
          state_nxt = IDLE;
          capture   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state-holding logic uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      read_ch_q <= '0;
      rr_ptr    <= CH_W'(CH_N - 1);
    end else begin
      state <= state_nxt;
      if (load_ch) read_ch_q <= next_ch;
      // Pointer advances only on completion; an abort re-requests the same channel.
      if (capture) rr_ptr <= read_ch_q;
    end
  end

  assign bus.read_req = (state == REQ);
  assign bus.read_ch  = read_ch_q;

  // FIFO control. A full FIFO still accepts a push when the head leaves on the same edge.
  assign pop     = bus.write_req & bus.write_ready;
  assign push_ok = capture & ((fifo_level != FULL_LVL) | pop);
  assign drop    = capture & ~push_ok;

  // NOTE: the storage array has no reset; validity is tracked by fifo_level,
  // so stale contents are never visible on the outputs.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      data_mem[wr_ptr] <= bus.read_data;
      ch_mem[wr_ptr]   <= read_ch_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      // Pointers are ADDR_W bits wide, so increments wrap modulo FIFO_DEPTH.
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      overflow <= drop;
    end
  end

`ifdef AD_MOVER_DROP_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

  assign bus.write_req  = (fifo_level != '0);
  assign bus.write_data = bus.write_req ? data_mem[rd_ptr] : '0;
  assign bus.write_ch   = bus.write_req ? ch_mem[rd_ptr]   : '0;

endmodule

// File: tb/tb_ad_mover_mc.sv
// tb_ad_mover_mc: directed self-checking bench for ad_mover_mc
// (CH_N=4, FIFO_DEPTH=8). Inputs change and outputs are sampled on the
// falling clock edge; the DUT acts on the rising edge.
module tb_ad_mover_mc;

  logic        clk;
  logic        reset;
  logic        ad_en;
  logic        read_quite;
  logic [3:0]  ch_mask;
  logic [3:0]  fifo_level;
  logic        overflow;
`ifdef AD_MOVER_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  ad_mover_mc_if #(.DATA_W(16), .CH_W(2)) bus ();

  ad_mover_mc #(
    .DATA_W(16), .CH_N(4), .CH_W(2), .FIFO_DEPTH(8), .ADDR_W(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ad_en      (ad_en),
    .read_quite (read_quite),
    .ch_mask    (ch_mask),
    .bus        (bus),
    .fifo_level (fifo_level),
    .overflow   (overflow)
`ifdef AD_MOVER_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read_req"},   32'(bus.read_req),   0);
    check({tag, "_read_ch"},    32'(bus.read_ch),    0);
    check({tag, "_write_req"},  32'(bus.write_req),  0);
    check({tag, "_write_data"}, 32'(bus.write_data), 0);
    check({tag, "_write_ch"},   32'(bus.write_ch),   0);
    check({tag, "_fifo_level"}, 32'(fifo_level),     0);
    check({tag, "_overflow"},   32'(overflow),       0);
`ifdef AD_MOVER_DROP_CNT_EN
    check({tag, "_drop_cnt"},   32'(drop_cnt),       0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rr_exp [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    logic [15:0] d;

    reset = 1'b0; ad_en = 1'b0; read_quite = 1'b0; ch_mask = 4'b0000;
    bus.read_ready = 1'b0; bus.read_data = '0; bus.write_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    @(negedge clk);

    // Round-robin scan over mask 1011 with no backpressure.
    ch_mask = 4'b1011; bus.write_ready = 1'b1; bus.read_ready = 1'b1; ad_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      d = 16'h1000 + 16'(i) * 16'h0111;
      check("rr_req", 32'(bus.read_req), 1);
      check("rr_ch",  32'(bus.read_ch),  32'(rr_exp[i]));
      bus.read_data = d;
      @(negedge clk);
      check("rr_gap",   32'(bus.read_req),   0);
      check("rr_wreq",  32'(bus.write_req),  1);
      check("rr_wch",   32'(bus.write_ch),   32'(rr_exp[i]));
      check("rr_wdata", 32'(bus.write_data), 32'(d));
      if (i == 5) ad_en = 1'b0;
      @(negedge clk);
    end
    check("rr_level_end", 32'(fifo_level), 0);

    // Backpressure: 10 captures into an 8-deep FIFO, last two dropped.
    ch_mask = 4'b0001; bus.write_ready = 1'b0; ad_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check("bp_req", 32'(bus.read_req), 1);
      bus.read_data = 16'h2000 + 16'(k);
      @(negedge clk);
      check("bp_ovf", 32'(overflow), (k >= 8) ? 1 : 0);
      if (k == 9) ad_en = 1'b0;
      @(negedge clk);
    end
    check("bp_ovf_pulse", 32'(overflow),       0);
    check("bp_level",     32'(fifo_level),     8);
    check("bp_head",      32'(bus.write_data), 32'h2000);
`ifdef AD_MOVER_DROP_CNT_EN
    check("bp_drop_cnt",  32'(drop_cnt),       2);
`endif

    // Full FIFO: capture and pop on the same edge.
    ad_en = 1'b1;
    @(negedge clk);
    check("fp_req", 32'(bus.read_req), 1);
    bus.read_data = 16'h2AAA; bus.write_ready = 1'b1;
    @(negedge clk);
    check("fp_ovf",   32'(overflow),       0);
    check("fp_level", 32'(fifo_level),     8);
    check("fp_head",  32'(bus.write_data), 32'h2001);
    ad_en = 1'b0;
    for (int j = 0; j < 8; j++) begin
      d = (j < 7) ? 16'h2001 + 16'(j) : 16'h2AAA;
      check("drain_wreq", 32'(bus.write_req),  1);
      check("drain_data", 32'(bus.write_data), 32'(d));
      check("drain_ch",   32'(bus.write_ch),   0);
      @(negedge clk);
    end
    check("drain_level", 32'(fifo_level),     0);
    check("drain_wreq0", 32'(bus.write_req),  0);
    check("drain_data0", 32'(bus.write_data), 0);

    // Abort with simultaneous read_ready; pointer must stay put (last ch 0).
    ch_mask = 4'b0101; bus.read_ready = 1'b1; ad_en = 1'b1;
    @(negedge clk);
    check("ab_req", 32'(bus.read_req), 1);
    check("ab_ch",  32'(bus.read_ch),  2);
    read_quite = 1'b1;
    @(negedge clk);
    check("ab_req_low", 32'(bus.read_req),  0);
    check("ab_nocap",   32'(fifo_level),    0);
    check("ab_wreq",    32'(bus.write_req), 0);
    read_quite = 1'b0; bus.read_ready = 1'b0;
    @(negedge clk);
    check("resume_req", 32'(bus.read_req), 1);
    check("resume_ch",  32'(bus.read_ch),  2);

    // Mask change mid-request: in-flight request keeps tag 2.
    ch_mask = 4'b0001;
    @(negedge clk);
    check("mm_hold_req", 32'(bus.read_req), 1);
    check("mm_hold_ch",  32'(bus.read_ch),  2);
    bus.read_ready = 1'b1; bus.read_data = 16'h5555;
    @(negedge clk);
    check("mm_wreq",  32'(bus.write_req),  1);
    check("mm_wch",   32'(bus.write_ch),   2);
    check("mm_wdata", 32'(bus.write_data), 32'h5555);
    @(negedge clk);
    check("mm_next_req", 32'(bus.read_req), 1);
    check("mm_next_ch",  32'(bus.read_ch),  0);
    bus.read_data = 16'h6666;
    @(negedge clk);

    // Empty mask: no requests.
    ch_mask = 4'b0000;
    for (int m = 0; m < 3; m++) begin
      @(negedge clk);
      check("mask0_req", 32'(bus.read_req), 0);
    end

    // Reset mid-stream with 5 entries queued and a request pending on ch 1.
    ch_mask = 4'b0010; bus.write_ready = 1'b0; bus.read_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      bus.read_data = 16'h7000 + 16'(k);
      @(negedge clk);
      if (k == 4) bus.read_ready = 1'b0;
      @(negedge clk);
    end
    check("mr_level", 32'(fifo_level),  5);
    check("mr_req",   32'(bus.read_req), 1);
    check("mr_ch",    32'(bus.read_ch),  1);
    #2 reset = 1'b0;
    #1 check_reset_outputs("mr_async");
    @(negedge clk);
    ch_mask = 4'b1010;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_req", 32'(bus.read_req), 1);
    check("post_rst_ch",  32'(bus.read_ch),  1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
